// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit computer fetch path: bus widths,
// the fetch state encoding and instruction-register field helpers.
package cpu_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int OPCODE_W  = 4;
    localparam int OPERAND_W = 4;

    // Width of the timeout counter covers TIMEOUT up to 255,
    // retry counter covers MAX_RETRY up to 15.
    localparam int TIMER_W = 8;
    localparam int RETRY_W = 4;

    localparam logic [OPCODE_W-1:0] DEFAULT_HLT_OPCODE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_RETRY  = 3'd2,
        ST_ADV    = 3'd3,
        ST_HOLD   = 3'd4,
        ST_HALTED = 3'd5,
        ST_FAULT  = 3'd6
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] ir_opcode(input logic [DATA_W-1:0] ir);
        return ir[DATA_W-1 -: OPCODE_W];
    endfunction

    function automatic logic [OPERAND_W-1:0] ir_operand(input logic [DATA_W-1:0] ir);
        return ir[OPERAND_W-1:0];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch stage, program memory and the decoder.
// master = fetch stage, slave = memory/decoder side.
interface instr_fetch_if;
    import cpu_pkg::*;

    // program memory read channel
    logic                 mem_req;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_ack;
    logic [DATA_W-1:0]    mem_data;

    // instruction register towards the decoder
    logic                 ir_valid;
    logic                 ir_ready;
    logic [OPCODE_W-1:0]  opcode;
    logic [OPERAND_W-1:0] operand;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data,
        output ir_valid,
        input  ir_ready,
        output opcode,
        output operand
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data,
        input  ir_valid,
        output ir_ready,
        input  opcode,
        input  operand
    );

endinterface

// File: rtl/fetch_watchdog.sv
// Timeout and retry bookkeeping for one memory fetch.
//   clear : both counters to zero (fetch not in progress)
//   start : a retry begins - retry count +1, timeout count restarts
//   tick  : one more cycle spent waiting for mem_ack
// timeout flags the last permitted waiting cycle (count == TIMEOUT-1),
// exhausted flags that the retry budget is already used up.
module fetch_watchdog
    import cpu_pkg::*;
#(
    parameter int TIMEOUT   = 15,
    parameter int MAX_RETRY = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    input  logic tick,
    output logic timeout,
    output logic exhausted
);

    localparam logic [TIMER_W-1:0] TC_LAST     = TIMER_W'(TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic [TIMER_W-1:0] r_tcnt;
    logic [RETRY_W-1:0] r_rcnt;

    // counter update; clear has priority so a fresh fetch always starts from zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcnt <= '0;
            r_rcnt <= '0;
        end else if (clear) begin
            r_tcnt <= '0;
            r_rcnt <= '0;
        end else if (start) begin
            r_tcnt <= '0;
            r_rcnt <= r_rcnt + 1'b1;
        end else if (tick) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    assign timeout   = (r_tcnt == TC_LAST);
    assign exhausted = (r_rcnt == RETRY_LIMIT);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads one byte from program memory at the
// program counter, holds it in the IR for the decoder and pulses advance
// once per fetched instruction. Stops for good on HLT or on a fetch that
// keeps timing out.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for run; nothing outstanding
// REQ     | mem_req high, waiting for mem_ack, timeout counter running
// RETRY   | one-cycle mem_req gap after a timeout, same address follows
// ADV     | byte captured; advance pulse steps the program counter
// HOLD    | ir_valid high until the decoder takes the instruction
// HALTED  | HLT consumed; halt high until reset
// FAULT   | retry budget exhausted; fault high until reset
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                  TIMEOUT    = 15,
    parameter int                  MAX_RETRY  = 3,
    parameter logic [OPCODE_W-1:0] HLT_OPCODE = DEFAULT_HLT_OPCODE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc,
    output logic              advance,
    output logic              halt,
    output logic              fault,
    instr_fetch_if.master     bus
);

    fetch_state_t      r_state;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_ir;
    logic              r_ir_valid;
    logic              r_advance;
    logic              r_halt;
    logic              r_fault;

    logic w_tick;
    logic w_start;
    logic w_clear;
    logic w_timeout;
    logic w_exhausted;

    // Counters only matter across REQ/RETRY; every other state holds them
    // at zero so each new fetch starts with a full budget.
    assign w_tick  = (r_state == ST_REQ);
    assign w_start = (r_state == ST_RETRY);
    assign w_clear = (r_state != ST_REQ) && (r_state != ST_RETRY);

    fetch_watchdog #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .start     (w_start),
        .clear     (w_clear),
        .tick      (w_tick),
        .timeout   (w_timeout),
        .exhausted (w_exhausted)
    );

    // Fetch FSM with all outputs registered alongside the state.
    // mem_req is set on entry to REQ and cleared on exit, so it is high
    // exactly while the state is REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_advance  <= 1'b0;
            r_halt     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_advance <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state    <= ST_REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= pc;
                    end
                end

                ST_REQ: begin
                    // an ack in the timeout cycle still delivers the byte
                    if (bus.mem_ack) begin
                        r_ir      <= bus.mem_data;
                        r_mem_req <= 1'b0;
                        r_advance <= 1'b1;
                        r_state   <= ST_ADV;
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        if (w_exhausted) begin
                            r_fault <= 1'b1;
                            r_state <= ST_FAULT;
                        end else begin
                            r_state <= ST_RETRY;
                        end
                    end
                end

                ST_RETRY: begin
                    r_mem_req <= 1'b1;
                    r_state   <= ST_REQ;
                end

                ST_ADV: begin
                    r_ir_valid <= 1'b1;
                    r_state    <= ST_HOLD;
                end

                ST_HOLD: begin
                    // pc has already stepped during ADV, so latching it here
                    // gives the address of the next instruction
                    if (r_ir_valid && bus.ir_ready) begin
                        r_ir_valid <= 1'b0;
                        if (ir_opcode(r_ir) == HLT_OPCODE) begin
                            r_halt  <= 1'b1;
                            r_state <= ST_HALTED;
                        end else if (run) begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= pc;
                            r_state    <= ST_REQ;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end

                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_mem_req  <= 1'b0;
                    r_ir_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req  = r_mem_req;
    assign bus.mem_addr = r_mem_addr;
    assign bus.ir_valid = r_ir_valid;
    assign bus.opcode   = ir_opcode(r_ir);
    assign bus.operand  = ir_operand(r_ir);
    assign advance      = r_advance;
    assign halt         = r_halt;
    assign fault        = r_fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch with TIMEOUT=4, MAX_RETRY=3.
module tb_instr_fetch;

    localparam int TO    = 4;
    localparam int MR    = 3;
    localparam int NRAND = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] pc;
    logic       advance;
    logic       halt;
    logic       fault;

    int n_pass  = 0;
    int n_total = 0;

    instr_fetch_if bus();

    instr_fetch #(
        .TIMEOUT    (TO),
        .MAX_RETRY  (MR),
        .HLT_OPCODE (4'hF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .pc      (pc),
        .advance (advance),
        .halt    (halt),
        .fault   (fault),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] data;
        int         dly;       // ack driven in cycle 1+dly (run seen in cycle 0)
        logic [3:0] exp_op;
        logic [3:0] exp_arg;
        int         exp_adv;   // cycle in which advance is expected
        logic       exp_halt;
        logic [7:0] exp_next;  // address of the following request
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] mem[256];
    logic [7:0] expq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        run          = 1'b0;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'h00;
        bus.ir_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    function automatic logic [7:0] ir_byte();
        return {bus.opcode, bus.operand};
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         adv_c, val_c, n_adv, fault_c, wait_n, dly, fetched, adv_n;
        int         addr_err, stab_err;
        logic       hold_ok, addr_ok, pattern_ok, exp_req, post_ok, prev_pending, done;
        logic [7:0] held, pc0, prev_ir, e;

        vecs[0] = '{8'h10, 8'h3A, 1, 4'h3, 4'hA, 3, 1'b0, 8'h11};
        vecs[1] = '{8'hFF, 8'h5C, 0, 4'h5, 4'hC, 2, 1'b0, 8'h00};
        vecs[2] = '{8'h42, 8'h81, 2, 4'h8, 4'h1, 4, 1'b0, 8'h43};
        vecs[3] = '{8'h7E, 8'h96, 3, 4'h9, 4'h6, 5, 1'b0, 8'h7F};
        vecs[4] = '{8'h90, 8'h27, 5, 4'h2, 4'h7, 7, 1'b0, 8'h91};
        vecs[5] = '{8'h00, 8'hEF, 0, 4'hE, 4'hF, 2, 1'b0, 8'h01};
        vecs[6] = '{8'h20, 8'hF0, 0, 4'hF, 4'h0, 2, 1'b1, 8'h00};

        // ---------------- reset values ----------------
        reset = 1'b1; run = 1'b0; pc = 8'h00;
        bus.mem_ack = 1'b0; bus.mem_data = 8'h00; bus.ir_ready = 1'b0;
        #3 reset = 1'b0;
        #1;
        chk("rst_mem_req",  32'(bus.mem_req), 32'(0));
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
        chk("rst_ir",       32'(ir_byte()), 32'(0));
        chk("rst_flags",    32'({bus.ir_valid, advance, halt, fault}), 32'(0));
        step();
        reset = 1'b1;
        step();
        step();
        chk("idle_no_req", 32'(bus.mem_req), 32'(0));

        // ---------------- async reset mid-REQ, late ack ignored ----------------
        pc = 8'hA5; run = 1'b1;
        step();
        chk("req_started", 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, 8'hA5}));
        run = 1'b0;
        #3 reset = 1'b0;
        #1;
        chk("async_rst", 32'({bus.mem_req, bus.mem_addr, bus.ir_valid, advance}), 32'(0));
        step();
        reset = 1'b1;
        step();
        step();
        bus.mem_ack = 1'b1; bus.mem_data = 8'h55;
        step();
        bus.mem_ack = 1'b0;
        chk("late_ack_ignored", 32'({advance, bus.mem_req, ir_byte()}), 32'(0));
        step();
        chk("late_ack_idle", 32'({bus.ir_valid, bus.mem_req, advance}), 32'(0));

        // ---------------- table-driven single fetches with backpressure ----------------
        for (int i = 0; i < 7; i++) begin
            do_reset();
            pc = vecs[i].pc; run = 1'b1; bus.ir_ready = 1'b0;
            adv_c = -1; val_c = -1; n_adv = 0; hold_ok = 1'b1; addr_ok = 1'b1; held = 8'h00;
            for (int c = 1; c <= 14; c++) begin
                step();
                if (advance) begin
                    n_adv++;
                    if (adv_c < 0) adv_c = c;
                    pc = pc + 8'd1;
                end
                if (bus.mem_req && bus.mem_addr != vecs[i].pc) addr_ok = 1'b0;
                if (bus.ir_valid && val_c < 0) begin
                    val_c = c;
                    held  = ir_byte();
                end
                if (val_c >= 0 && (!bus.ir_valid || bus.mem_req || ir_byte() != held)) hold_ok = 1'b0;
                if (c == 1 + vecs[i].dly) begin
                    bus.mem_ack = 1'b1; bus.mem_data = vecs[i].data;
                end else begin
                    bus.mem_ack = 1'b0; bus.mem_data = 8'($urandom);
                end
            end
            bus.mem_ack = 1'b0;
            chk($sformatf("v%0d_adv_cycle", i),   32'(adv_c), 32'(vecs[i].exp_adv));
            chk($sformatf("v%0d_valid_cycle", i), 32'(val_c), 32'(vecs[i].exp_adv + 1));
            chk($sformatf("v%0d_adv_once", i),    32'(n_adv), 32'(1));
            chk($sformatf("v%0d_ir", i),          32'({bus.opcode, bus.operand}),
                32'({vecs[i].exp_op, vecs[i].exp_arg}));
            chk($sformatf("v%0d_req_addr", i),    32'(addr_ok), 32'(1));
            chk($sformatf("v%0d_hold_stable", i), 32'(hold_ok), 32'(1));
            bus.ir_ready = 1'b1;
            step();
            bus.ir_ready = 1'b0;
            chk($sformatf("v%0d_valid_drop", i), 32'(bus.ir_valid), 32'(0));
            if (vecs[i].exp_halt)
                chk($sformatf("v%0d_halted", i), 32'({halt, bus.mem_req}), 32'({1'b1, 1'b0}));
            else
                chk($sformatf("v%0d_next_req", i), 32'({halt, bus.mem_req, bus.mem_addr}),
                    32'({1'b0, 1'b1, vecs[i].exp_next}));
        end

        // ---------------- timeout / retry / fault ----------------
        do_reset();
        pc = 8'h33; run = 1'b1;
        pattern_ok = 1'b1; fault_c = -1;
        for (int c = 1; c <= 30; c++) begin
            step();
            exp_req = (c < (MR + 1) * (TO + 1)) && (c % (TO + 1) != 0);
            if (bus.mem_req !== exp_req) pattern_ok = 1'b0;
            if (bus.mem_req && bus.mem_addr != 8'h33) pattern_ok = 1'b0;
            if (advance) pattern_ok = 1'b0;
            if (fault && fault_c < 0) fault_c = c;
            if (c >= 22) begin
                bus.mem_ack = 1'b1; bus.mem_data = 8'h12;
            end
        end
        bus.mem_ack = 1'b0;
        chk("fault_cycle",   32'(fault_c), 32'((MR + 1) * (TO + 1)));
        chk("retry_pattern", 32'(pattern_ok), 32'(1));
        chk("fault_sticky",  32'({fault, bus.mem_req, bus.ir_valid, halt, ir_byte()}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));

        // ---------------- randomized program against a reference model ----------------
        do_reset();
        pc0 = 8'($urandom);
        expq.delete();
        for (int i = 0; i < NRAND; i++) begin
            e = {4'($urandom_range(0, 14)), 4'($urandom)};
            mem[8'(pc0 + 8'(i))] = e;
            expq.push_back(e);
        end
        e = {4'hF, 4'($urandom)};
        mem[8'(pc0 + 8'(NRAND))] = e;
        expq.push_back(e);

        pc = pc0; run = 1'b1;
        fetched = 0; adv_n = 0; wait_n = 0; dly = $urandom_range(0, 3);
        addr_err = 0; stab_err = 0; prev_pending = 1'b0; prev_ir = 8'h00; done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            step();
            if (halt) begin
                done = 1'b1;
            end else begin
                if (advance) begin
                    adv_n++;
                    pc = pc + 8'd1;
                end
                if (prev_pending && (!bus.ir_valid || ir_byte() != prev_ir)) stab_err++;
                if (bus.mem_req) begin
                    if (bus.mem_addr != 8'(pc0 + 8'(fetched))) addr_err++;
                    if (wait_n == dly) begin
                        bus.mem_ack = 1'b1; bus.mem_data = mem[bus.mem_addr];
                        wait_n = 0; dly = $urandom_range(0, 3);
                    end else begin
                        bus.mem_ack = 1'b0; bus.mem_data = 8'($urandom);
                        wait_n++;
                    end
                end else begin
                    bus.mem_ack  = ($urandom_range(0, 3) == 0);
                    bus.mem_data = 8'($urandom);
                end
                bus.ir_ready = ($urandom_range(0, 2) != 0);
                if (bus.ir_valid && bus.ir_ready) begin
                    if (expq.size() > 0) e = expq.pop_front();
                    else e = 8'hXX;
                    chk($sformatf("rand_ir_%0d", fetched), 32'(ir_byte()), 32'(e));
                    fetched++;
                    prev_pending = 1'b0;
                end else begin
                    prev_pending = bus.ir_valid;
                end
                prev_ir = ir_byte();
            end
        end
        bus.mem_ack = 1'b0;
        chk("rand_halted",    32'(halt), 32'(1));
        chk("rand_all_taken", 32'(expq.size()), 32'(0));
        chk("rand_adv_count", 32'(adv_n), 32'(NRAND + 1));
        chk("rand_addr",      32'(addr_err), 32'(0));
        chk("rand_ir_stable", 32'(stab_err), 32'(0));

        // halted: nothing more happens even with run high and acks arriving
        post_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.mem_ack  = 1'b1;
            bus.mem_data = 8'($urandom);
            bus.ir_ready = 1'b1;
            step();
            if (bus.mem_req || advance || bus.ir_valid || !halt || bus.opcode != 4'hF) post_ok = 1'b0;
        end
        bus.mem_ack = 1'b0;
        chk("halt_sticky", 32'(post_ok), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
